// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit.
// MD_* op encodings live beside the ALU_* encodings used by the single-cycle ALU.
// Encodings 3'd0 and 3'd7 are no-ops.
package mul_div_unit_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational HI/LO result for the multiply/divide ops.
// Ports:
//   md_op_i  op encoding (MD_*)
//   a_i      rs operand / dividend
//   b_i      rt operand / divisor
//   hi_o     HI result (product upper half / remainder)
//   lo_o     LO result (product lower half / quotient)
// Divide by zero yields lo = all ones, hi = dividend. Signed MIN / -1 yields lo = MIN, hi = 0.
import mul_div_unit_pkg::*;

module md_result_calc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       md_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] s_a, s_b, u_a, u_b, s_prod, u_prod;
  logic [WIDTH-1:0]   abs_a, abs_b, mag_q, mag_r, s_quot, s_rem, u_quot, u_rem;
  logic               a_neg, b_neg, b_zero, s_ovf;

  // Sign-extend to 2*WIDTH so a modulo-2^(2W) product is the exact signed product.
  assign s_a    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign s_b    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign u_a    = {{WIDTH{1'b0}}, a_i};
  assign u_b    = {{WIDTH{1'b0}}, b_i};
  assign s_prod = s_a * s_b;
  assign u_prod = u_a * u_b;

  assign a_neg  = a_i[WIDTH-1];
  assign b_neg  = b_i[WIDTH-1];
  assign b_zero = (b_i == '0);
  assign s_ovf  = (a_i == MinVal) && (b_i == '1);

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
  assign abs_a  = a_neg ? (~a_i + 1'b1) : a_i;
  assign abs_b  = b_neg ? (~b_i + 1'b1) : b_i;
  assign mag_q  = b_zero ? '0 : (abs_a / abs_b);
  assign mag_r  = b_zero ? '0 : (abs_a % abs_b);
  assign s_quot = (a_neg ^ b_neg) ? (~mag_q + 1'b1) : mag_q;
  assign s_rem  = a_neg ? (~mag_r + 1'b1) : mag_r;
  assign u_quot = b_zero ? '0 : (a_i / b_i);
  assign u_rem  = b_zero ? '0 : (a_i % b_i);

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    case (md_op_i)
      MD_MULT: begin
        hi_o = s_prod[2*WIDTH-1:WIDTH];
        lo_o = s_prod[WIDTH-1:0];
      end
      MD_MULTU: begin
        hi_o = u_prod[2*WIDTH-1:WIDTH];
        lo_o = u_prod[WIDTH-1:0];
      end
      MD_DIV: begin
        if (b_zero) begin
          hi_o = a_i;
          lo_o = '1;
        end else if (s_ovf) begin
          hi_o = '0;
          lo_o = MinVal;
        end else begin
          hi_o = s_rem;
          lo_o = s_quot;
        end
      end
      MD_DIVU: begin
        if (b_zero) begin
          hi_o = a_i;
          lo_o = '1;
        end else begin
          hi_o = u_rem;
          lo_o = u_quot;
        end
      end
      default: begin
        hi_o = '0;
        lo_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, sitting in EX beside the ALU.
// The result is computed combinationally at issue and parked in pending registers; it is
// committed to hi/lo after a fixed latency, which models the real unit's timing.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset, clears all state
//   start   op valid this cycle
//   md_op   MD_* op encoding
//   A, B    operands (sampled only at issue)
//   cancel  abort in-flight op (exception flush); wins over start and over the final commit
//   busy    op in flight
//   hi, lo  architectural HI/LO registers
import mul_div_unit_pkg::*;

module mul_div_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MulCnt = CntW'(MUL_CYCLES);
  localparam logic [CntW-1:0] DivCnt = CntW'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] hi_n, lo_n;

  md_result_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .md_op_i(md_op),
    .a_i    (A),
    .b_i    (B),
    .hi_o   (hi_n),
    .lo_o   (lo_n)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          if (md_is_long(md_op)) begin
            pend_hi_d = hi_n;
            pend_lo_d = lo_n;
            cnt_d     = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? MulCnt : DivCnt;
            state_d   = StRun;
          end else if (md_op == MD_MTHI) begin
            hi_d = A;
          end else if (md_op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      StRun: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntW'(1)) begin
          // Final edge of the latency window: commit.
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic results, latency, MTHI/MTLO, cancel and reset.
import mul_div_unit_pkg::*;

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        cancel;
  logic        busy;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  mul_div_unit #(
    .WIDTH     (32),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .cancel(cancel),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op for a single cycle; returns at the negedge after its issue edge.
  // Operands are scrambled afterwards to show they are only sampled at issue.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_NOP;
    A     = 32'h5A5A_1234;
    B     = 32'h0BAD_F00D;
  endtask

  // Count negedges with busy high, starting at the first negedge after issue. Bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    md_op  = MD_NOP;
    A      = '0;
    B      = '0;
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;

    // 1: MULT -3 * 7 = -21
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_busy_t0", 32'(busy), 32'd1);
    check("mult_hi_stale", hi, 32'd0);
    wait_idle(cyc);
    check("mult_cycles", 32'(cyc), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // 2: MULTU FFFFFFFF * 2
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(cyc);
    check("multu_cycles", 32'(cyc), 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // 3: DIV -7 / 2 -> q=-3, r=-1
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    check("div_cycles", 32'(cyc), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIV 7 / -2 -> q=-3, r=1
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(cyc);
    check("div_negb_lo", lo, 32'hFFFF_FFFD);
    check("div_negb_hi", hi, 32'd1);

    // DIV overflow MIN / -1
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // DIV by zero, negative dividend
    issue(MD_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_idle(cyc);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFFB);

    // DIVU 100 / 7 -> q=14, r=2
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_idle(cyc);
    check("divu_cycles", 32'(cyc), 32'd10);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // 4: DIVU 7 / 0
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_idle(cyc);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_0007);

    // 5: MTHI then MTLO in idle
    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'hFFFF_FFFF);
    check("mthi_busy", 32'(busy), 32'd0);
    issue(MD_MTLO, 32'hAAAA_5555, 32'd0);
    check("mtlo_lo", lo, 32'hAAAA_5555);
    check("mtlo_hi", hi, 32'h1234_5678);

    // MTLO while busy is ignored
    issue(MD_MULTU, 32'd3, 32'd4);
    start = 1'b1;
    md_op = MD_MTLO;
    A     = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_NOP;
    check("mtlo_busy_ignored", lo, 32'hAAAA_5555);
    wait_idle(cyc);
    check("mtlo_run_lo", lo, 32'h0000_000C);
    check("mtlo_run_hi", hi, 32'd0);

    // 6: MULT cancelled at cycle 2
    issue(MD_MULT, 32'd2, 32'd3);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_lo", lo, 32'h0000_000C);
    repeat (6) @(negedge clk);
    check("cancel_no_late_lo", lo, 32'h0000_000C);

    // Cancel on the final edge wins over commit
    issue(MD_MULTU, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    check("final_edge_busy", 32'(busy), 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("final_cancel_busy", 32'(busy), 32'd0);
    check("final_cancel_lo", lo, 32'h0000_000C);

    // Cancel and start together in idle: op not started
    @(negedge clk);
    start  = 1'b1;
    md_op  = MD_MTHI;
    A      = 32'hCAFE_0001;
    cancel = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    md_op  = MD_NOP;
    check("cancel_start_hi", hi, 32'd0);
    issue(MD_MULT, 32'd9, 32'd9);
    check("start_after_cancel_busy", 32'(busy), 32'd1);
    wait_idle(cyc);
    check("start_after_cancel_lo", lo, 32'd81);

    // Async reset mid-DIV
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_hi", hi, 32'd0);
    check("areset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("areset_discard_lo", lo, 32'd0);
    check("areset_discard_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
